// File: rtl/cpu_types_pkg.sv
// Shared execute-stage types: data word, multiply/divide opcodes and FSM states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      RUN  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } mdu_state_t;

   localparam int MDU_ITERS = 32;
   localparam int MDU_CNT_W = $clog2(MDU_ITERS);

   function automatic logic mdu_is_div(input mdu_op_t op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic mdu_is_signed(input mdu_op_t op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// acc = {upper, lower}; multiply keeps the multiplier in lower, divide the quotient.
module mdu_step
   import cpu_types_pkg::*;
(
   input  logic        is_div_i,
   input  logic [63:0] acc_i,
   input  word_t       operand_i,
   output logic [63:0] acc_o
);

   logic [32:0] sum;
   logic [32:0] shifted;
   logic [32:0] diff;
   logic        ge;

   always_comb begin
      sum     = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, operand_i} : 33'd0);
      // 33-bit partial remainder: old remainder plus the next dividend bit
      shifted = acc_i[63:31];
      diff    = shifted - {1'b0, operand_i};
      ge      = (shifted >= {1'b0, operand_i});
      if (is_div_i) begin
         acc_o = {(ge ? diff[31:0] : shifted[31:0]), acc_i[30:0], ge};
      end else begin
         acc_o = {sum, acc_i[31:1]};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding architectural HI/LO.
// Fixed 34-cycle busy window (PREP + 32 RUN + FIX) for every op, including divide-by-zero.
//
//   state | meaning
//   IDLE  | no operation, HI/LO writable, start accepted
//   PREP  | load accumulator from latched magnitudes, clear counter
//   RUN   | 32 iterations of mdu_step
//   FIX   | sign fix-up / divide-by-zero override, HI/LO written on exit
//   DONE  | result visible, done pulse, start accepted back-to-back
module mult_div_unit
   import cpu_types_pkg::*;
#(
   parameter word_t DIVZ_LO = 32'hFFFFFFFF
)(
   input  logic    CLK,
   input  logic    nRST,
   input  logic    start,
   input  mdu_op_t op,
   input  word_t   opa,
   input  word_t   opb,
   input  logic    flush,
   input  logic    hi_wen,
   input  logic    lo_wen,
   input  word_t   wdat,
   output logic    busy,
   output logic    done,
   output word_t   hi,
   output word_t   lo
);

   mdu_state_t           state_q, state_d;
   mdu_op_t              op_q, op_d;
   word_t                opa_q, opa_d;
   word_t                mag_a_q, mag_a_d;
   word_t                mag_b_q, mag_b_d;
   logic                 neg_a_q, neg_a_d;
   logic                 neg_b_q, neg_b_d;
   logic                 divz_q, divz_d;
   logic [63:0]          acc_q, acc_d;
   logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
   word_t                hi_q, hi_d;
   word_t                lo_q, lo_d;

   logic        is_div;
   logic        is_sgn;
   logic        launch;
   logic        sgn_new;
   logic [63:0] step_acc;
   word_t       fix_hi;
   word_t       fix_lo;
   logic [63:0] prod;

   assign is_div = mdu_is_div(op_q);
   assign is_sgn = mdu_is_signed(op_q);

   mdu_step u_step (
      .is_div_i  (is_div),
      .acc_i     (acc_q),
      .operand_i (is_div ? mag_b_q : mag_a_q),
      .acc_o     (step_acc)
   );

   always_comb begin
      prod   = acc_q;
      fix_hi = acc_q[63:32];
      fix_lo = acc_q[31:0];
      if (is_div) begin
         if (divz_q) begin
            fix_hi = opa_q;
            fix_lo = DIVZ_LO;
         end else begin
            if (is_sgn && neg_a_q)              fix_hi = ~acc_q[63:32] + 32'd1;
            if (is_sgn && (neg_a_q ^ neg_b_q))  fix_lo = ~acc_q[31:0] + 32'd1;
         end
      end else begin
         if (is_sgn && (neg_a_q ^ neg_b_q)) prod = ~acc_q + 64'd1;
         fix_hi = prod[63:32];
         fix_lo = prod[31:0];
      end
   end

   assign busy    = (state_q == PREP) || (state_q == RUN) || (state_q == FIX);
   assign done    = (state_q == DONE);
   assign launch  = !busy && start && !flush;
   assign sgn_new = mdu_is_signed(op);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      opa_d   = opa_q;
      mag_a_d = mag_a_q;
      mag_b_d = mag_b_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      divz_d  = divz_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (launch) begin
               state_d = PREP;
               op_d    = op;
               opa_d   = opa;
               neg_a_d = sgn_new && opa[31];
               neg_b_d = sgn_new && opb[31];
               mag_a_d = (sgn_new && opa[31]) ? ~opa + 32'd1 : opa;
               mag_b_d = (sgn_new && opb[31]) ? ~opb + 32'd1 : opb;
            end
         end
         PREP: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               state_d = RUN;
               acc_d   = {32'd0, (is_div ? mag_a_q : mag_b_q)};
               cnt_d   = '0;
               divz_d  = is_div && (mag_b_q == 32'd0);
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               acc_d = step_acc;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == MDU_CNT_W'(MDU_ITERS - 1)) state_d = FIX;
            end
         end
         FIX: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
               hi_d    = fix_hi;
               lo_d    = fix_lo;
            end
         end
         default: state_d = IDLE;
      endcase
      // MTHI/MTLO only land outside the busy window; in DONE they override the result
      if (!busy && hi_wen) hi_d = wdat;
      if (!busy && lo_wen) lo_d = wdat;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         op_q    <= MDU_MULT;
         opa_q   <= '0;
         mag_a_q <= '0;
         mag_b_q <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         divz_q  <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         opa_q   <= opa_d;
         mag_a_q <= mag_a_d;
         mag_b_q <= mag_b_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         divz_q  <= divz_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes expected HI/LO and done cycle,
// a negedge monitor pops and compares whenever done is seen.
module tb_mult_div_unit;
   import cpu_types_pkg::*;

   logic    CLK = 1'b0;
   logic    nRST;
   logic    start;
   mdu_op_t op;
   word_t   opa, opb;
   logic    flush, hi_wen, lo_wen;
   word_t   wdat;
   logic    busy, done;
   word_t   hi, lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          dcyc;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   mult_div_unit dut (
      .CLK(CLK), .nRST(nRST), .start(start), .op(op), .opa(opa), .opb(opb),
      .flush(flush), .hi_wen(hi_wen), .lo_wen(lo_wen), .wdat(wdat),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference: plain two's-complement arithmetic, {hi, lo}
   function automatic logic [63:0] model(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
      longint p;
      int     sa, sb;
      case (o)
         MDU_MULT: begin
            p = longint'($signed(a)) * longint'($signed(b));
            return 64'(p);
         end
         MDU_MULTU: return {32'd0, a} * {32'd0, b};
         MDU_DIVU: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
            sa = $signed(a);
            sb = $signed(b);
            return {32'(sa % sb), 32'(sa / sb)};
         end
      endcase
   endfunction

   always @(negedge CLK) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("result_hi", hi, e.hi);
            check("result_lo", lo, e.lo);
            check("done_cycle", 32'(cyc), 32'(e.dcyc));
         end
      end
   end

   // Drives start for one edge; returns the cycle index just after the sampling edge
   task automatic launch(input mdu_op_t o, input word_t a, input word_t b, output int n0);
      start = 1'b1; op = o; opa = a; opb = b;
      @(posedge CLK); #1;
      n0 = cyc;
      start = 1'b0;
   endtask

   // Full op with scoreboard entry; returns at the negedge where done is high
   task automatic run_op(input mdu_op_t o, input word_t a, input word_t b, input bit mthi_busy);
      int   n0, nbusy;
      bit   seen;
      exp_t e;
      logic [63:0] r;
      r = model(o, a, b);
      launch(o, a, b, n0);
      e.hi = r[63:32]; e.lo = r[31:0]; e.dcyc = n0 + 34;
      sb_q.push_back(e);
      nbusy = 0;
      seen  = 0;
      for (int k = 0; k < 60 && !seen; k++) begin
         if (mthi_busy && k == 5) begin hi_wen = 1'b1; wdat = 32'hDEADBEEF; end
         if (mthi_busy && k == 7) hi_wen = 1'b0;
         @(negedge CLK);
         if (done) seen = 1;
         else if (busy) nbusy++;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout: got no done expected done within 60 cycles");
      end
      check("busy_cycles", 32'(nbusy), 32'd34);
   endtask

   initial begin
      int   n0;
      logic [31:0] a, b;
      mdu_op_t o;
      nRST = 1'b0; start = 0; op = MDU_MULT; opa = 0; opb = 0;
      flush = 0; hi_wen = 0; lo_wen = 0; wdat = 0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_hi", hi, 0); check("rst_lo", lo, 0);
      check("rst_busy", 32'(busy), 0); check("rst_done", 32'(done), 0);
      nRST = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         check("idle_stable", {hi[15:0], lo[15:0]} | 32'(busy) | 32'(done), 0);
      end

      @(posedge CLK); #1;
      run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      run_op(MDU_MULT, 32'hFFFFFFFD, 32'd7, 0);
      run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 0);
      run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
      run_op(MDU_DIVU, 32'd5, 32'd0, 0);
      run_op(MDU_DIV, 32'hFFFFFFF9, 32'd0, 0);
      run_op(MDU_DIVU, 32'd7, 32'd2, 0);

      // flush at RUN counter 10 keeps prior hi=1, lo=3
      launch(MDU_MULTU, 32'd2, 32'd2, n0);
      repeat (11) @(posedge CLK);
      #1 flush = 1'b1;
      @(posedge CLK); #1 flush = 1'b0;
      check("flush_busy", 32'(busy), 0);
      check("flush_hi", hi, 32'd1);
      check("flush_lo", lo, 32'd3);
      repeat (40) @(posedge CLK);
      check("flush_hold_lo", lo, 32'd3);

      // reset mid-RUN clears immediately
      #1;
      launch(MDU_MULTU, 32'd2, 32'd2, n0);
      repeat (8) @(posedge CLK);
      #1 nRST = 1'b0;
      #1;
      check("rstmid_hi", hi, 0); check("rstmid_lo", lo, 0);
      check("rstmid_busy", 32'(busy), 0);
      @(posedge CLK); #1 nRST = 1'b1;
      repeat (40) @(posedge CLK);
      #1;

      // MTHI while busy ignored, then MTHI in DONE overrides
      run_op(MDU_MULTU, 32'd6, 32'd7, 1);
      hi_wen = 1'b1; wdat = 32'hDEADBEEF;
      @(posedge CLK); #1 hi_wen = 1'b0;
      check("mthi_done", hi, 32'hDEADBEEF);
      check("mthi_keep_lo", lo, 32'd42);

      // back-to-back from DONE, then MTLO in DONE
      run_op(MDU_DIVU, 32'd100, 32'd7, 0);
      run_op(MDU_MULT, 32'h80000000, 32'h80000000, 0);
      lo_wen = 1'b1; wdat = 32'h12345678;
      @(posedge CLK); #1 lo_wen = 1'b0;
      check("mtlo_done", lo, 32'h12345678);

      // start + MTHI together in IDLE: HI written now, result overwrites later
      @(posedge CLK); #1;
      hi_wen = 1'b1; wdat = 32'hCAFEF00D;
      start = 1'b1; op = MDU_DIVU; opa = 32'd9; opb = 32'd4;
      @(posedge CLK); #1;
      n0 = cyc; start = 0; hi_wen = 0;
      check("mthi_with_start", hi, 32'hCAFEF00D);
      begin
         exp_t e;
         e.hi = 32'd1; e.lo = 32'd2; e.dcyc = n0 + 34;
         sb_q.push_back(e);
      end
      repeat (36) @(posedge CLK);
      #1;

      for (int i = 0; i < 40; i++) begin
         o = mdu_op_t'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: a = 32'h80000000;
            2: b = 32'hFFFFFFFF;
            3: b = $urandom_range(1, 20);
            default: ;
         endcase
         run_op(o, a, b, 0);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge CLK); #1;
         end
      end

      repeat (5) @(posedge CLK);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage.
- Consumes the two register-file read words (rdat1 → opa, rdat2 → opb) for MULT/MULTU/DIV/DIVU and holds the 64-bit result in architectural HI/LO registers.
- MFHI/MFLO read hi/lo; MTHI/MTLO write them.
- Multi-cycle; the hazard unit stalls on busy.

Parameters:
DIVZ_LO, 32'hFFFFFFFF, value written to LO on divide-by-zero (HI gets the dividend)

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
start  input  1  launch an operation; sampled only in IDLE or DONE
op  input  2  mdu_op_t: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU
opa  input  32  word_t; multiplicand or dividend (rs)
opb  input  32  word_t; multiplier or divisor (rt)
flush  input  1  abort the in-flight operation (branch mispredict/squash)
hi_wen  input  1  MTHI write enable
lo_wen  input  1  MTLO write enable
wdat  input  32  word_t; MTHI/MTLO data
busy  output  1  operation in flight (PREP, RUN, FIX)
done  output  1  one-cycle pulse; hi/lo hold the new result
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, nRST low):
  - state=IDLE; hi=lo=0; busy=0; done=0; iteration counter=0.
  - Asserting reset mid-operation aborts immediately.
- FSM states: IDLE → PREP → RUN → FIX → DONE → IDLE.
  - From DONE, start=1 goes directly to PREP (back-to-back issue).
- IDLE/DONE + start=1:
  - Latch op, opa, opb.
  - For signed ops, record signs and take magnitudes as 32-bit unsigned. abs(0x80000000)=0x80000000.
- PREP: one cycle; load datapath registers; counter=0.
- RUN: exactly 32 cycles, one iteration each; counter 0..31. Leave at counter==31.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; 32-bit remainder, 33-bit compare.
- FIX: one cycle.
  - Signed multiply: negate the 64-bit product if the signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - All arithmetic is modulo 2^32, so DIV 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Register writes on the FIX→DONE edge:
  - Multiply: hi=product[63:32], lo=product[31:0].
  - Divide: lo=quotient, hi=remainder.
- Divide by zero (opb==0, detected in PREP): RUN still runs 32 cycles so latency is fixed. Result is hi=opa (unsigned original value), lo=DIVZ_LO.
- Latency: start sampled at edge E0 → done high in the cycle following edge E0+34; busy high for cycles E0+1 .. E0+34 (PREP, RUN, FIX).
- done: high only in DONE, exactly one cycle.
- flush in PREP/RUN/FIX: next edge returns to IDLE; hi/lo unchanged; done never asserted. flush in IDLE/DONE: no effect, except start is ignored that cycle.
- MTHI/MTLO (hi_wen/lo_wen):
  - Honoured only when busy=0 (IDLE or DONE); ignored while busy.
  - In DONE they override the just-written result.
  - Simultaneous start + hi_wen in IDLE: HI is written now; the later result overwrites it.
- start while busy: ignored; no queueing.
- op encodings outside the enum cannot occur; treat as MDU_MULTU.

Decomposition:
- cpu_types_pkg additions:
  - mdu_op_t (2-bit enum): MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11.
  - mdu_state_t: IDLE, PREP, RUN, FIX, DONE.
  - MDU_ITERS=32.
- One natural sub-module: mdu_step, purely combinational.
  - Given op class, accumulator/remainder and operand, it produces the next-iteration values.
  - The parent holds the FSM, counter, sign fix-up and HI/LO.

Test Plan:
- Reset then idle → hi=0, lo=0, busy=0, done=0; after release, start=0 for 10 cycles → no change.
- MULTU opa=0xFFFFFFFF opb=0xFFFFFFFF at edge E0 → busy cycles E0+1..E0+34, done single pulse after E0+34, hi=0xFFFFFFFE, lo=0x00000001.
- Signed ops:
  - MULT −3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 7/2 → lo=3, hi=1. DIVU 5/0 → hi=5, lo=0xFFFFFFFF, same 34-cycle latency.
- Abort and reset:
  - Prior result hi=1, lo=3; start MULTU 2×2; flush at RUN counter=10 → IDLE next edge, no done, hi=1, lo=3.
  - Repeat with nRST pulsed low mid-RUN → hi=lo=0 immediately.
- MTHI/MTLO:
  - MTHI wdat=0xDEADBEEF while busy → ignored; result overwrites normally.
  - Same write in DONE → hi=0xDEADBEEF.
  - Back-to-back start in DONE → next done exactly 34 cycles later.
